iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
- Multi-cycle shift unit. Takes operand A and shift amount B, then performs SLL, SRL or SRA over several cycles, moving at most STEP bits per cycle.
- Sits beside the ALU as the responder for shift requests. Uses a start/busy/done handshake, so a controller or bench can issue one request at a time and collect a registered result.

Parameters:
- STEP, 1, maximum bits shifted per cycle. Legal values are 1..32.
- WIDTH, 32, datapath width. Fixed at 32 for this CPU; the parameter is exposed for the bench only.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe, sampled on a clk edge while the unit is idle.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR/reserved.
- A  in  32  operand to shift.
- B  in  32  shift amount. Only B[4:0] is used; B[31:5] is ignored.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse marking that result is newly valid.
- result  out  32  registered result, held until the next accepted request.

Behaviour:
- Reset values: busy=0, done=0, result=0. FSM goes to IDLE, internal accumulator and counter are cleared.
- FSM states: IDLE and SHIFT.
- IDLE, start=1: latch acc=A, cnt=B[4:0], op. Go to SHIFT, busy=1, done=0.
- IDLE, start=0: stay in IDLE; done is 0 after its pulse cycle.
- SHIFT, cnt!=0: s=min(cnt,STEP). Apply the op to acc by s bits; cnt<=cnt-s.
- SHIFT, cnt==0: result<=acc, done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Shift semantics:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with acc[31].
  - All results are truncated to 32 bits.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+ceil(B[4:0]/STEP)+1.
  - B=0: done after edge k+1.
  - B=5, STEP=1: done after edge k+6.
- start while busy=1 is ignored: no latch, no error, and the in-flight operation is unaffected.
- start in the same cycle done=1 is accepted, since the FSM is already in IDLE. busy rises on the next edge.
- A, B and op may change freely after acceptance; only the latched copies are used.
- reset mid-operation aborts the request: no done pulse, result=0.
- reset has priority over start in the same cycle.
- result changes only on the done edge and on reset.

Optional Feature:
- Macro: SHIFT_ROT_EN.
- Defined: op=11 is ROTR. Bits shifted out of acc[0] re-enter at acc[31]. Latency is the same as the other ops.
- Undefined: op=11 behaves exactly as SRL and no rotate logic is synthesized.

Decomposition:
- Shared package, reused by the ALU decoder:
  - op encoding constants SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROTR.
  - state constants S_IDLE, S_SHIFT.
- One combinational sub-module, shift_step. Inputs are acc, s, op; output is the shifted acc. It is instantiated once and contains all fill and rotate logic.
- The parent holds the FSM, counter and registers.

Test Plan:
- SRA, STEP=1: A=32'h7FFFF800, B=5, op=10. busy is high for 6 cycles, then done pulses with result=32'h03FFFFC0.
- SLL, STEP=1: A=32'h7FFFF800, B=5, op=00 gives result=32'hFFFF0000. SRA A=32'h80000000, B=4 gives 32'hF8000000. SRL with the same A and B gives 32'h08000000.
- B=0 and B=32'h25 (only B[4:0]=5 counts), STEP=4:
  - B=0: done after 2 edges, result=A.
  - B=32'h25 with A=32'h7FFFF800, op=10: done after 4 edges, result=32'h03FFFFC0.
- Handshake:
  - start pulsed during busy with different A: ignored, and the first result is unchanged.
  - start asserted in the done cycle: accepted, and busy rises on the next edge.
- reset asserted on the 3rd SHIFT cycle: busy=0, done never pulses, result=0. A new start afterwards completes normally.
- SHIFT_ROT_EN defined: A=32'h00000001, B=1, op=11 gives 32'h80000000. Undefined: the same stimulus gives 32'h00000000.

Source files
------------

// File: rtl/iter_shift_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iter_shift_unit_pkg
// Description : Shared definitions for the iterative shift unit and the ALU
//               decoder: shift operation encodings and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package iter_shift_unit_pkg;

    // Shift operation encoding (op field)
    localparam logic [1:0] SHIFT_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_SRL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_ROTR = 2'b11;

    // Control FSM states
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

endpackage : iter_shift_unit_pkg
`default_nettype wire

// File: rtl/iter_shift_unit_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter. Shifts acc_i by s_i bits
//               according to op_i (SLL / SRL / SRA / ROTR).
//               Build option SHIFT_ROT_EN: when defined, op=11 rotates right;
//               when undefined, op=11 behaves as SRL and no rotate logic exists.
// Ports       : acc_i  - accumulator value to shift
//               s_i    - shift distance for this step
//               op_i   - operation encoding
//               acc_o  - shifted accumulator
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import iter_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [SW-1:0]    s_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] acc_o
);

`ifdef SHIFT_ROT_EN
    // Left-shift distance that brings the bits dropped off the LSB end back
    // in at the MSB end. For s_i=0 this is WIDTH, which shifts everything out.
    logic [SW:0] w_rot_lsh;
    assign w_rot_lsh = (SW+1)'(WIDTH) - {1'b0, s_i};
`endif

    always_comb begin
        acc_o = acc_i >> s_i;
        case (op_i)
            SHIFT_SLL: acc_o = acc_i << s_i;
            SHIFT_SRL: acc_o = acc_i >> s_i;
            SHIFT_SRA: acc_o = $signed(acc_i) >>> s_i;
`ifdef SHIFT_ROT_EN
            SHIFT_ROTR: acc_o = (acc_i >> s_i) | (acc_i << w_rot_lsh);
`else
            SHIFT_ROTR: acc_o = acc_i >> s_i;
`endif
            default: acc_o = acc_i >> s_i;
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : iter_shift_unit
// Description : Multi-cycle shift unit. Accepts operand A and amount B[4:0]
//               on start while idle, then shifts at most STEP bits per cycle
//               and presents a registered result with a one-cycle done pulse.
//               Build option SHIFT_ROT_EN enables ROTR for op=11 (otherwise
//               op=11 is SRL).
// Ports       : clk    - clock, rising edge
//               reset  - synchronous active-high reset
//               start  - request strobe, honoured only while idle
//               op     - 00 SLL, 01 SRL, 10 SRA, 11 ROTR/SRL
//               A      - operand
//               B      - shift amount (low bits only)
//               busy   - request in progress
//               done   - one-cycle pulse, result newly valid
//               result - registered result
// Parameters  : STEP (1..32) max bits per cycle; WIDTH fixed at 32
// Revision    : 1.0 - initial release
// ============================================================================
module iter_shift_unit
    import iter_shift_unit_pkg::*;
#(
    parameter int STEP  = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [31:0]      B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SW = $clog2(WIDTH);
    // One extra bit so that STEP=WIDTH is representable for the min() compare
    localparam logic [SW:0] STEP_C = (SW+1)'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [SW-1:0]    w_s;
    logic [WIDTH-1:0] w_step_acc;
    logic             w_unused_b;

    // Upper bits of the shift amount are architecturally ignored
    assign w_unused_b = ^B[31:SW];

    // s = min(cnt, STEP). When STEP >= 2**SW the else branch is unreachable
    // because cnt can never reach STEP.
    assign w_s = ({1'b0, cnt_q} < STEP_C) ? cnt_q : STEP_C[SW-1:0];

    shift_step #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_shift_step (
        .acc_i (acc_q),
        .s_i   (w_s),
        .op_i  (op_q),
        .acc_o (w_step_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= SHIFT_SLL;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = A;
                    cnt_d   = B[SW-1:0];
                    op_d    = op;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = w_step_acc;
                    cnt_d = cnt_q - w_s;
                end else begin
                    // Remaining count exhausted: publish and return to idle
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = done_q;
    assign result = result_q;

endmodule : iter_shift_unit
`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_shift_unit
// Description : Self-checking bench for iter_shift_unit. Two instances share
//               the clock and reset: index 0 uses STEP=1, index 1 uses STEP=4.
//               Directed vectors with hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_shift_unit;
    import iter_shift_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start  [2];
    logic [1:0]  op_s   [2];
    logic [31:0] a_s    [2];
    logic [31:0] b_s    [2];
    logic        busy   [2];
    logic        done   [2];
    logic [31:0] result [2];

    int n_checks = 0;
    int n_errors = 0;

    iter_shift_unit #(.STEP(1), .WIDTH(32)) u_dut_s1 (
        .clk    (clk),
        .reset  (reset),
        .start  (start[0]),
        .op     (op_s[0]),
        .A      (a_s[0]),
        .B      (b_s[0]),
        .busy   (busy[0]),
        .done   (done[0]),
        .result (result[0])
    );

    iter_shift_unit #(.STEP(4), .WIDTH(32)) u_dut_s4 (
        .clk    (clk),
        .reset  (reset),
        .start  (start[1]),
        .op     (op_s[1]),
        .A      (a_s[1]),
        .B      (b_s[1]),
        .busy   (busy[1]),
        .done   (done[1]),
        .result (result[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on instance sel starting now (just after a clock
    // edge); returns just after the edge on which done becomes visible.
    // pulse_at >= 0 raises a stray start (different operands) while busy.
    task automatic do_op(input int sel, input logic [31:0] a_v, input logic [31:0] b_v,
                         input logic [1:0] op_v, input logic [31:0] exp_res,
                         input string tag, input int pulse_at);
        int n;
        int busy_cnt;
        int step;
        int lat_exp;
        step    = (sel == 0) ? 1 : 4;
        lat_exp = (int'(b_v[4:0]) + step - 1) / step + 1;
        start[sel] = 1'b1;
        a_s[sel]   = a_v;
        b_s[sel]   = b_v;
        op_s[sel]  = op_v;
        @(posedge clk); #1;
        start[sel] = 1'b0;
        // Scramble inputs: only the latched copies may matter now
        a_s[sel]   = $urandom;
        b_s[sel]   = $urandom;
        op_s[sel]  = 2'($urandom);
        check_eq({tag, "_busy_rise"}, 32'(busy[sel]), 32'd1);
        check_eq({tag, "_done_low"}, 32'(done[sel]), 32'd0);
        n = 0;
        busy_cnt = 1;
        while (done[sel] !== 1'b1 && n < 200) begin
            if (n == pulse_at) begin
                start[sel] = 1'b1;
                a_s[sel]   = 32'h1234_5678;
                b_s[sel]   = 32'h0000_0001;
                op_s[sel]  = SHIFT_SLL;
            end
            @(posedge clk); #1;
            n++;
            start[sel] = 1'b0;
            if (busy[sel] === 1'b1) busy_cnt++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(lat_exp));
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat_exp));
        check_eq({tag, "_result"}, result[sel], exp_res);
        check_eq({tag, "_busy_fall"}, 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        logic [31:0] rot_exp1;
        logic [31:0] rot_exp2;
        int          done_seen;
`ifdef SHIFT_ROT_EN
        rot_exp1 = 32'h8000_0000;
        rot_exp2 = 32'hC400_0003;
`else
        rot_exp1 = 32'h0000_0000;
        rot_exp2 = 32'h0000_0003;
`endif
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            op_s[i]  = 2'b00;
            a_s[i]   = 32'h0;
            b_s[i]   = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            check_eq($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
            check_eq($sformatf("rst_result%0d", i), result[i], 32'h0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // STEP=1 vectors
        do_op(0, 32'h7FFF_F800, 32'd5, SHIFT_SRA, 32'h03FF_FFC0, "s1_sra5", -1);
        // Still in the done cycle: the next request starts here
        check_eq("s1_done_cycle", 32'(done[0]), 32'd1);
        do_op(0, 32'h7FFF_F800, 32'd5, SHIFT_SLL, 32'hFFFF_0000, "s1_sll5", -1);
        do_op(0, 32'h8000_0000, 32'd4, SHIFT_SRA, 32'hF800_0000, "s1_sra4", -1);
        do_op(0, 32'h8000_0000, 32'd4, SHIFT_SRL, 32'h0800_0000, "s1_srl4", -1);
        do_op(0, 32'h7FFF_F800, 32'd5, SHIFT_SRA, 32'h03FF_FFC0, "s1_ignore", 2);
        do_op(0, 32'h0000_0001, 32'd1, SHIFT_ROTR, rot_exp1, "s1_rotr1", -1);

        // STEP=4 vectors
        do_op(1, 32'hDEAD_BEEF, 32'd0, SHIFT_SRA, 32'hDEAD_BEEF, "s4_b0", -1);
        do_op(1, 32'h7FFF_F800, 32'h25, SHIFT_SRA, 32'h03FF_FFC0, "s4_b25", -1);
        do_op(1, 32'h8000_0001, 32'd7, SHIFT_SRA, 32'hFF00_0000, "s4_sra7", -1);
        do_op(1, 32'h0000_0001, 32'd31, SHIFT_SLL, 32'h8000_0000, "s4_sll31", -1);
        do_op(1, 32'h0000_00F1, 32'd6, SHIFT_ROTR, rot_exp2, "s4_rotr6", -1);

        // Reset during the third SHIFT cycle aborts the request
        @(posedge clk); #1;
        start[0] = 1'b1;
        a_s[0]   = 32'h0000_F0F0;
        b_s[0]   = 32'd5;
        op_s[0]  = SHIFT_SRL;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_busy", 32'(busy[0]), 32'd0);
        check_eq("abort_done", 32'(done[0]), 32'd0);
        check_eq("abort_result", result[0], 32'h0);
        done_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) done_seen++;
        end
        check_eq("abort_no_done", 32'(done_seen), 32'd0);
        do_op(0, 32'h0000_F0F0, 32'd5, SHIFT_SRL, 32'h0000_0787, "after_abort", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_iter_shift_unit
`default_nettype wire
